// File: rtl/nmk112_pkg.sv
// Shared widths, table-paging limit and bank register type for the NMK112
// OKI sample-ROM bank mapper.
package nmk112_pkg;

    localparam int unsigned OKI_AW = 18;
    localparam int unsigned ROM_AW = 21;
    localparam int unsigned BANK_W = 8;
    localparam int unsigned NBANK  = 4;

    localparam logic [OKI_AW-1:0] TABLE_LIMIT = 18'h00400;

    typedef logic [BANK_W-1:0] bank_t;

endpackage

// File: rtl/nmk112_bank_mapper_if.sv
// Z80 bank-write bus and OKI address request/response for one mapper.
// master: bus driver (Z80 / OKI side); slave: the mapper.
interface nmk112_bank_mapper_if;
    import nmk112_pkg::*;

    logic              WE;
    logic [2:0]        OFFSET;
    bank_t             DATA;
    logic [OKI_AW-1:0] REQ_ADDR;
    logic [ROM_AW-1:0] REQ_DATA_ADDR;

    modport master (
        output WE,
        output OFFSET,
        output DATA,
        output REQ_ADDR,
        input  REQ_DATA_ADDR
    );

    modport slave (
        input  WE,
        input  OFFSET,
        input  DATA,
        input  REQ_ADDR,
        output REQ_DATA_ADDR
    );

endinterface

// File: rtl/nmk112_regfile.sv
// Four-entry write-only bank register file with asynchronous reset.
// All banks are exposed so the mapper can select combinationally.
module nmk112_regfile
    import nmk112_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic [1:0] sel_i,
    input  bank_t      data_i,
    output bank_t      bank_o [NBANK]
);

    bank_t bank_q [NBANK];
    bank_t bank_d [NBANK];

    // Next state: only the addressed register takes the written value.
    always_comb begin
        bank_d = bank_q;
        if (we_i) begin
            bank_d[sel_i] = data_i;
        end
    end

    // Bank register storage, cleared to zero on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_q <= '{default: '0};
        end else begin
            bank_q <= bank_d;
        end
    end

    assign bank_o = bank_q;

endmodule

// File: rtl/nmk112_bank_mapper.sv
// NMK112 per-OKI sample-ROM bank mapper: picks a bank register from the OKI
// address, forms {bank[4:0], addr[15:0]} + ROM_OFFS and registers it.
// Optional macro NMK112_PAGE_TABLE_EN: addresses below 0x400 select the bank
// from REQ_ADDR[9:8] so each voice gets its own phrase-table bank.
module nmk112_bank_mapper
    import nmk112_pkg::*;
#(
    parameter logic [ROM_AW-1:0] ROM_OFFS = 21'h000000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    nmk112_bank_mapper_if.slave     bus
);

    bank_t             banks [NBANK];
    logic [1:0]        sel;
    bank_t             sel_bank;
    logic [ROM_AW-1:0] addr_d;
    logic [ROM_AW-1:0] addr_q;

    nmk112_regfile u_regfile (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .we_i   (bus.WE),
        .sel_i  (bus.OFFSET[2:1]),
        .data_i (bus.DATA),
        .bank_o (banks)
    );

    // Bank selection and address formation.
    always_comb begin
        sel = bus.REQ_ADDR[17:16];
`ifdef NMK112_PAGE_TABLE_EN
        if (bus.REQ_ADDR < TABLE_LIMIT) begin
            sel = bus.REQ_ADDR[9:8];
        end
`endif
        sel_bank = banks[sel];
        // Full bank byte is summed at 24 bits; bank[7:5] only reaches bits
        // 23:21, which the truncation to ROM_AW discards (mod 2^21 wrap).
        addr_d = ROM_AW'({3'b000, ROM_OFFS} + {sel_bank, bus.REQ_ADDR[15:0]});
    end

    // Output address register; resets to the mapping of address 0, bank 0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_q <= ROM_OFFS;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign bus.REQ_DATA_ADDR = addr_q;

endmodule

// File: tb/tb_nmk112_bank_mapper.sv
// Directed bench for nmk112_bank_mapper: two instances (ROM_OFFS 0 and
// 0x100000) driven in lockstep, expected addresses queued when a request is
// driven and compared after the following rising edge.
module tb_nmk112_bank_mapper;
    import nmk112_pkg::*;

    logic clk;
    logic rst;

    int unsigned checks;
    int unsigned errors;

    bank_t             mbank [NBANK];
    logic [ROM_AW-1:0] exp0_q [$];
    logic [ROM_AW-1:0] exp1_q [$];
    string             tag_q  [$];

    nmk112_bank_mapper_if bus0 ();
    nmk112_bank_mapper_if bus1 ();

    nmk112_bank_mapper #(.ROM_OFFS(21'h000000)) u_dut0 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus0)
    );

    nmk112_bank_mapper #(.ROM_OFFS(21'h100000)) u_dut1 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference mapping from the bench's own copy of the bank registers.
    function automatic logic [ROM_AW-1:0] model(input logic [ROM_AW-1:0] offs,
                                                input logic [OKI_AW-1:0] a);
        logic [1:0] s;
        s = a[17:16];
`ifdef NMK112_PAGE_TABLE_EN
        if (a < 18'h00400) s = a[9:8];
`endif
        return offs + {mbank[s][4:0], a[15:0]};
    endfunction

    task automatic cmp(input string tag, input logic [ROM_AW-1:0] obs,
                       input logic [ROM_AW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        string tag;
        logic [ROM_AW-1:0] e0;
        logic [ROM_AW-1:0] e1;
        tag = tag_q.pop_front();
        e0  = exp0_q.pop_front();
        e1  = exp1_q.pop_front();
        cmp({tag, "_offs0"}, bus0.REQ_DATA_ADDR, e0);
        cmp({tag, "_offs1"}, bus1.REQ_DATA_ADDR, e1);
    endtask

    // One clock: drive write + lookup, queue expectations from the old banks,
    // then apply the write to the model and compare after the edge.
    task automatic step(input logic we, input logic [2:0] off, input bank_t d,
                        input logic [OKI_AW-1:0] a, input string tag);
        @(negedge clk);
        bus0.WE = we; bus0.OFFSET = off; bus0.DATA = d; bus0.REQ_ADDR = a;
        bus1.WE = we; bus1.OFFSET = off; bus1.DATA = d; bus1.REQ_ADDR = a;
        exp0_q.push_back(model(21'h000000, a));
        exp1_q.push_back(model(21'h100000, a));
        tag_q.push_back(tag);
        if (we) mbank[off[2:1]] = d;
        @(posedge clk);
        #1;
        check_out();
        bus0.WE = 1'b0;
        bus1.WE = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int unsigned i = 0; i < NBANK; i++) mbank[i] = '0;
        bus0.WE = 1'b0; bus0.OFFSET = '0; bus0.DATA = '0; bus0.REQ_ADDR = '0;
        bus1.WE = 1'b0; bus1.OFFSET = '0; bus1.DATA = '0; bus1.REQ_ADDR = '0;

        // Power-on reset
        rst = 1'b1;
        #1;
        cmp("reset_offs0", bus0.REQ_DATA_ADDR, 21'h000000);
        cmp("reset_offs1", bus1.REQ_DATA_ADDR, 21'h100000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic map: bank[1]=05, OFFSET[0] ignored on a second write
        step(1'b1, 3'b010, 8'h05, 18'h00000, "wr_b1");
        step(1'b0, 3'b000, 8'h00, 18'h12345, "basic_map");
        step(1'b1, 3'b011, 8'h09, 18'h12345, "wr_b1_odd");
        step(1'b0, 3'b000, 8'h00, 18'h12345, "odd_offset");
        step(1'b1, 3'b010, 8'h05, 18'h00000, "wr_b1_back");

        // Bank width and wrap
        step(1'b1, 3'b110, 8'hFF, 18'h00000, "wr_b3");
        step(1'b0, 3'b000, 8'h00, 18'h3FFFF, "wrap");
        step(1'b0, 3'b000, 8'h00, 18'h12345, "b1_unchanged");

        // Write/lookup collision and back-to-back writes
        step(1'b1, 3'b000, 8'h02, 18'h00000, "wr_b0");
        step(1'b1, 3'b000, 8'h07, 18'h00800, "coll_old");
        step(1'b0, 3'b000, 8'h00, 18'h00800, "coll_new");
        step(1'b1, 3'b100, 8'h11, 18'h00000, "b2b_first");
        step(1'b1, 3'b100, 8'h0A, 18'h00000, "b2b_second");
        step(1'b0, 3'b000, 8'h00, 18'h20010, "b2b_last_wins");

        // Table paging
        step(1'b1, 3'b000, 8'h01, 18'h00000, "pg_b0");
        step(1'b1, 3'b010, 8'h02, 18'h00000, "pg_b1");
        step(1'b1, 3'b100, 8'h03, 18'h00000, "pg_b2");
        step(1'b1, 3'b110, 8'h04, 18'h00000, "pg_b3");
        step(1'b0, 3'b000, 8'h00, 18'h00210, "page_0210");
        step(1'b0, 3'b000, 8'h00, 18'h003FF, "page_03ff");
        step(1'b0, 3'b000, 8'h00, 18'h00400, "page_0400");

        // Mid-operation asynchronous reset
        step(1'b1, 3'b100, 8'h1C, 18'h2ABCD, "mid_wr_b2");
        step(1'b0, 3'b000, 8'h00, 18'h2ABCD, "mid_pre");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("mid_reset_offs0", bus0.REQ_DATA_ADDR, 21'h000000);
        cmp("mid_reset_offs1", bus1.REQ_DATA_ADDR, 21'h100000);
        for (int unsigned i = 0; i < NBANK; i++) mbank[i] = '0;
        #1;
        rst = 1'b0;
        step(1'b0, 3'b000, 8'h00, 18'h20001, "post_reset");
        step(1'b0, 3'b000, 8'h00, 18'h3FFFF, "post_reset_b3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nmk112_bank_mapper.md
# nmk112_bank_mapper

Per-OKI ADPCM sample-ROM bank switcher for the Batrider sound board. Holds four 8-bit bank registers written by the Z80 and maps the 18-bit address from one jt6295 onto a 21-bit sample-ROM address. Two instances are used, one per OKI; the second is relocated by `ROM_OFFS`.

## Interface

Parameters:
- `ROM_OFFS`, default 21'h000000: constant added to every output address; the second instance uses 21'h100000.

Ports:
- `CLK`  input  1  system clock (96 MHz domain); all state changes on the rising edge.
- `RESET`  input  1  reset; one clock, asynchronous and active-high.
- `WE`  input  1  bank-register write strobe, active-high for one cycle.
- `OFFSET`  input  3  register select; `OFFSET[2:1]` picks bank register 0..3, `OFFSET[0]` is ignored.
- `DATA`  input  8  bank value written when `WE`=1.
- `REQ_ADDR`  input  18  OKI sample address.
- `REQ_DATA_ADDR`  output  21  mapped ROM address, registered.

## Operation

- Four bank registers, `bank[0..3]`, each 8 bits.
- Write:
  - On a cycle with `WE`=1, `bank[OFFSET[2:1]] <= DATA`.
  - Other registers are unchanged.
  - `WE`=0 leaves all registers unchanged.
- Normal mapping:
  - sel = `REQ_ADDR[17:16]`.
  - `REQ_DATA_ADDR` = (`ROM_OFFS` + {`bank[sel][4:0]`, `REQ_ADDR[15:0]`}) mod 2^21.
  - `bank[sel][7:5]` are stored but do not affect the output.
  - The addition wraps at 2^21; no saturation and no error flag.
- Table paging (only with the macro, see Configuration):
  - Applies when `REQ_ADDR` < 18'h00400.
  - sel = `REQ_ADDR[9:8]` instead of `REQ_ADDR[17:16]`; the rest of the formula is unchanged.
  - This gives each of the four OKI voices its own phrase-table bank.
- Reset:
  - All `bank[]` = 8'h00.
  - `REQ_DATA_ADDR` = `ROM_OFFS`, i.e. the mapping of address 0 with bank 0.

## Timing

- Output latency: `REQ_DATA_ADDR` updates on the rising edge after `REQ_ADDR` changes. That is one cycle of latency, and the output is a registered flop.
- Write visibility: a bank write on edge N takes effect in the mapping computed on edge N+1. The output reflects it after edge N+1.
- Simultaneous write and lookup in the same cycle: the lookup uses the old bank value.
- Back-to-back writes to the same register on consecutive cycles: the last one wins.
- Reset asserted mid-operation: registers and output go to their reset values immediately, without waiting for a clock edge. Mapping resumes on the first edge after `RESET` deasserts.
- No handshake. The output is valid continuously one cycle after its inputs. The OKI's `rom_ok` timing tolerates this cycle.

## Configuration

- Macro `NMK112_PAGE_TABLE_EN`.
- Defined: table paging is active for `REQ_ADDR` < 18'h00400, as described in Operation.
- Undefined: all addresses, including 0..0x3FF, use sel = `REQ_ADDR[17:16]`. The comparator logic is not synthesized.

## Structure

- Shared package `nmk112_pkg`:
  - widths `OKI_AW`=18, `ROM_AW`=21, `BANK_W`=8, `NBANK`=4;
  - localparam `TABLE_LIMIT`=18'h00400;
  - typedef `bank_t` (logic [7:0]).
- One sub-module is natural: `nmk112_regfile`, the four-entry write-only register file with reset, exposing all four banks.
- The top module contains the selection mux, the adder and the output flop.

## Test plan

- Reset: with `ROM_OFFS`=0, apply `RESET` -> `REQ_DATA_ADDR`=21'h000000. With `ROM_OFFS`=21'h100000 -> 21'h100000.
- Basic map:
  - Write `bank[1]`=8'h05 (`OFFSET`=3'b010).
  - `REQ_ADDR`=18'h1_2345 -> one cycle later `REQ_DATA_ADDR`=21'h05_2345.
  - Same stimulus on the `ROM_OFFS`=21'h100000 instance -> 21'h15_2345.
- Bank width and wrap:
  - Write `bank[3]`=8'hFF, `REQ_ADDR`=18'h3_FFFF, `ROM_OFFS`=0 -> 21'h1F_FFFF.
  - With `ROM_OFFS`=21'h100000 -> 21'h0F_FFFF (wrapped).
- Write/lookup collision:
  - `bank[0]`=8'h02.
  - On cycle N, write `bank[0]`=8'h07 while `REQ_ADDR`=18'h0_0800.
  - Result after edge N+1 is 21'h02_0800; after edge N+2 it is 21'h07_0800.
- Table paging:
  - Setup: `bank[0..3]` = 8'h01, 02, 03, 04.
  - With `NMK112_PAGE_TABLE_EN` defined: `REQ_ADDR`=18'h0_0210 -> 21'h03_0210.
  - Without the macro: same address -> 21'h01_0210.
  - `REQ_ADDR`=18'h0_0400 -> 21'h01_0400 in both builds.
- Mid-operation reset:
  - Load nonzero banks, then pulse `RESET` between clock edges.
  - Expect the output to be `ROM_OFFS` immediately.
  - After deassertion, `REQ_ADDR`=18'h2_0001 -> `ROM_OFFS`+21'h00_0001.
